vga_ram_writer: RTL and testbench

Producer side of the display RAM consumed by the VGA adapter. Snapshots the 24 key note-on flags into the note-on region (addresses 4..27) and captures an oscilloscope-style, zero-crossing-triggered, decimated window of 160 audio samples into the output-history region (addresses 52..211). It owns the single RAM write port. Its word formats match what the display side decodes: bit 0 is note-on, bits 28:23 are the wave amplitude.

---
 rtl/vga_ram_writer_if.sv | 19 +
 rtl/vga_ram_writer.sv | 114 +++++++++++
 tb/tb_vga_ram_writer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_ram_writer_if.sv
// vga_ram_writer_if: audio/key inputs plus display RAM write port; master = writer side, slave = source/RAM side
interface vga_ram_writer_if #(parameter int NUM_KEYS = 24);
  logic [15:0] sample;
  logic sample_valid;
  logic [NUM_KEYS-1:0] notes_on;
  logic ram_we;
  logic [7:0] ram_waddr;
  logic [31:0] ram_din;
  logic capturing;
  logic frame_done;
  modport master (
    input sample, sample_valid, notes_on,
    output ram_we, ram_waddr, ram_din, capturing, frame_done
  );
  modport slave (
    output sample, sample_valid, notes_on,
    input ram_we, ram_waddr, ram_din, capturing, frame_done
  );
endinterface

// File: rtl/vga_ram_writer.sv
// vga_ram_writer: key note-on snapshot + zero-crossing-triggered decimated scope history into display RAM; ports clk, rst_n (async low), bus (sample/sample_valid/notes_on in; ram_we/ram_waddr/ram_din/capturing/frame_done out)
module vga_ram_writer #(
  parameter int NUM_KEYS = 24,
  parameter logic [7:0] NOTE_BASE = 8'd4,
  parameter logic [7:0] HIST_BASE = 8'd52,
  parameter int HIST_LEN = 160,
  parameter int DECIMATE = 4,
  parameter int TRIG_TIMEOUT = 2048
) (
  input logic clk,
  input logic rst_n,
  vga_ram_writer_if.master bus
);
  localparam int KW = $clog2(NUM_KEYS + 1);
  localparam int CW = $clog2(HIST_LEN);
  localparam int DW = $clog2(DECIMATE + 1);
  localparam int TW = $clog2(TRIG_TIMEOUT + 1);
  typedef enum logic [1:0] {NOTE_SCAN, ARM, CAPTURE} state_t;
  state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [CW-1:0] c_q, c_d;
  logic [DW-1:0] d_q, d_d;
  logic [TW-1:0] t_q, t_d;
  logic [NUM_KEYS-1:0] snap_q, snap_d;
  logic [15:0] prev_q;
  logic we_d, fd_d, cap_d, trig, timeout;
  logic [7:0] addr_d;
  logic [31:0] din_d, hist_word;
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    c_d = c_q;
    d_d = d_q;
    t_d = t_q;
    snap_d = snap_q;
    we_d = 1'b0;
    fd_d = 1'b0;
    addr_d = bus.ram_waddr;
    din_d = bus.ram_din;
    hist_word = {3'b0, ~bus.sample[15], bus.sample[14:10], 23'b0};
    trig = prev_q[15] && !bus.sample[15];
    timeout = t_q == TW'(TRIG_TIMEOUT - 1);
    case (state_q)
      NOTE_SCAN:
        if (k_q == KW'(NUM_KEYS)) begin
          state_d = ARM;
          t_d = '0;
        end else begin
          // k=0 takes the snapshot and writes straight from it in the same edge
          if (k_q == '0) snap_d = bus.notes_on;
          we_d = 1'b1;
          addr_d = NOTE_BASE + 8'(k_q);
          din_d = {31'b0, snap_d[k_q]};
          k_d = k_q + KW'(1);
        end
      ARM:
        if (bus.sample_valid) begin
          if (trig || timeout) begin
            state_d = CAPTURE;
            we_d = 1'b1;
            addr_d = HIST_BASE;
            din_d = hist_word;
            c_d = CW'(1);
            d_d = '0;
          end else t_d = t_q + TW'(1);
        end
      CAPTURE:
        if (bus.sample_valid) begin
          if (d_q == DW'(DECIMATE - 1)) begin
            d_d = '0;
            we_d = 1'b1;
            addr_d = HIST_BASE + 8'(c_q);
            din_d = hist_word;
            if (c_q == CW'(HIST_LEN - 1)) begin
              fd_d = 1'b1;
              state_d = NOTE_SCAN;
              k_d = '0;
            end else c_d = c_q + CW'(1);
          end else d_d = d_q + DW'(1);
        end
      default: state_d = NOTE_SCAN;
    endcase
    // held through the final column write, dropping one cycle later
    cap_d = (state_q == CAPTURE) || (state_d == CAPTURE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= NOTE_SCAN;
      k_q <= '0;
      c_q <= '0;
      d_q <= '0;
      t_q <= '0;
      snap_q <= '0;
      prev_q <= 16'h0000;
      bus.ram_we <= 1'b0;
      bus.ram_waddr <= 8'h00;
      bus.ram_din <= 32'h0;
      bus.capturing <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      c_q <= c_d;
      d_q <= d_d;
      t_q <= t_d;
      snap_q <= snap_d;
      if (bus.sample_valid) prev_q <= bus.sample;
      bus.ram_we <= we_d;
      bus.ram_waddr <= addr_d;
      bus.ram_din <= din_d;
      bus.capturing <= cap_d;
      bus.frame_done <= fd_d;
    end
endmodule

// File: tb/tb_vga_ram_writer.sv
// tb_vga_ram_writer: directed segments with random data checked against a trace-level model of the writer
module tb_vga_ram_writer;
  localparam int TO = 8, DEC = 4, HL = 160, NK = 24, MAXC = 2000;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  vga_ram_writer_if bus();
  vga_ram_writer #(.DECIMATE(DEC), .TRIG_TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
  int checks = 0, errors = 0;
  logic [15:0] s_in [MAXC];
  logic v_in [MAXC];
  logic [23:0] n_in [MAXC];
  logic e_we [MAXC], e_cap [MAXC], e_fd [MAXC];
  logic [7:0] e_addr [MAXC];
  logic [31:0] e_din [MAXC];
  logic o_we [MAXC], o_cap [MAXC], o_fd [MAXC];
  logic [7:0] o_addr [MAXC];
  logic [31:0] o_din [MAXC];
  logic [15:0] sine [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fmt(input logic [15:0] s);
    return {3'b0, ~s[15], s[14:10], 23'b0};
  endfunction

  function automatic logic [15:0] pick();
    int r = $urandom % 4;
    return r == 0 ? 16'h8000 : r == 1 ? 16'h0000 : r == 2 ? 16'h7FFF : 16'($urandom);
  endfunction

  function automatic void put(input int i, input int a, input logic [15:0] s, input int n);
    if (i < n) begin
      e_we[i] = 1'b1;
      e_addr[i] = 8'(a);
      e_din[i] = fmt(s);
    end
  endfunction

  // Expected output trace: out[t] shows the effect of inputs applied in cycle t-1.
  // Reset is released in cycle 0, which is the first note-scan entry cycle.
  function automatic void model(input int n);
    int e = 0, t = 0, cnt, col, d, t0;
    logic [15:0] prev = 16'h0000;
    for (int i = 0; i < MAXC; i++) begin
      e_we[i] = 0; e_cap[i] = 0; e_fd[i] = 0; e_addr[i] = 0; e_din[i] = 0;
    end
    while (e < n) begin
      for (int k = 0; k < NK; k++)
        if (e + 1 + k < n) begin
          e_we[e+1+k] = 1'b1;
          e_addr[e+1+k] = 8'(4 + k);
          e_din[e+1+k] = {31'b0, n_in[e][k]};
        end
      for (t = e; t < e + NK + 1 && t < n; t++) if (v_in[t]) prev = s_in[t];
      cnt = 0;
      t0 = -1;
      while (t < n && t0 < 0) begin
        if (v_in[t]) begin
          cnt++;
          if ((prev[15] && !s_in[t][15]) || cnt == TO) t0 = t;
          prev = s_in[t];
        end
        t++;
      end
      if (t0 < 0) break;
      put(t0 + 1, 52, s_in[t0], n);
      col = 1;
      d = 0;
      while (t < n && col < HL) begin
        if (v_in[t]) begin
          d++;
          prev = s_in[t];
          if (d == DEC) begin
            d = 0;
            put(t + 1, 52 + col, s_in[t], n);
            if (col == HL - 1 && t + 1 < n) e_fd[t+1] = 1'b1;
            col++;
          end
        end
        t++;
      end
      for (int i = t0 + 1; i <= t && i < n; i++) e_cap[i] = 1'b1;
      if (col < HL) break;
      e = t;
    end
  endfunction

  task automatic zeros(input string tag);
    chk({tag, "_we"}, 32'(bus.ram_we), 32'h0);
    chk({tag, "_addr"}, 32'(bus.ram_waddr), 32'h0);
    chk({tag, "_din"}, bus.ram_din, 32'h0);
    chk({tag, "_cap"}, 32'(bus.capturing), 32'h0);
    chk({tag, "_fd"}, 32'(bus.frame_done), 32'h0);
  endtask

  task automatic reset_hold(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      zeros("rst");
      bus.sample_valid = 1'($urandom % 2);
      bus.sample = 16'($urandom);
      bus.notes_on = 24'($urandom);
    end
  endtask

  task automatic run_seg(input int n);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int t = 0; t < n; t++) begin
      if (t > 0) begin
        @(posedge clk);
        #1;
      end
      o_we[t] = bus.ram_we; o_addr[t] = bus.ram_waddr; o_din[t] = bus.ram_din;
      o_cap[t] = bus.capturing; o_fd[t] = bus.frame_done;
      chk($sformatf("we@%0d", t), 32'(o_we[t]), 32'(e_we[t]));
      chk($sformatf("cap@%0d", t), 32'(o_cap[t]), 32'(e_cap[t]));
      chk($sformatf("fd@%0d", t), 32'(o_fd[t]), 32'(e_fd[t]));
      if (e_we[t]) begin
        chk($sformatf("addr@%0d", t), 32'(o_addr[t]), 32'(e_addr[t]));
        chk($sformatf("din@%0d", t), o_din[t], e_din[t]);
      end
      bus.sample = s_in[t];
      bus.sample_valid = v_in[t];
      bus.notes_on = n_in[t];
    end
  endtask

  initial begin
    int t8, cnt, stop;
    for (int i = 0; i < 16; i++) sine[i] = 16'($rtoi(28672.0 * $sin(2.0 * 3.14159265358979 * i / 16.0)));
    bus.sample = 16'h0; bus.sample_valid = 1'b0; bus.notes_on = 24'h0;
    #1 rst_n = 1'b0;
    reset_hold(8);

    // sine, valid every cycle; the rising crossing lands on the first ARM sample
    for (int t = 0; t < MAXC; t++) begin
      v_in[t] = 1'b1;
      s_in[t] = sine[(t + 7) % 16];
      n_in[t] = (t == 0) ? 24'h000005 : 24'($urandom);
    end
    model(1400);
    run_seg(1400);
    chk("note0", o_din[1], 32'h1);
    chk("note1", o_din[2], 32'h0);
    chk("note2", o_din[3], 32'h1);
    chk("note_last_addr", 32'(o_addr[24]), 32'd27);
    chk("arm_idle", 32'(o_we[25]), 32'h0);
    chk("col0_addr", 32'(o_addr[26]), 32'd52);
    chk("col0_din", o_din[26], 32'h1000_0000);
    chk("cap_rise", 32'(o_cap[26]), 32'h1);
    chk("fd_last", 32'(o_fd[662]), 32'h1);
    chk("fd_addr", 32'(o_addr[662]), 32'd211);
    chk("cap_fall", 32'(o_cap[663]), 32'h0);
    chk("rescan_addr", 32'(o_addr[663]), 32'd4);
    reset_hold(3);

    // constant positive level forces the timeout; then format corners
    for (int t = 0; t < MAXC; t++) begin
      v_in[t] = 1'($urandom % 2);
      s_in[t] = 16'h0100;
      n_in[t] = 24'($urandom);
    end
    cnt = 0;
    t8 = 25;
    while (t8 < 200) begin
      if (v_in[t8]) cnt++;
      if (cnt == TO) break;
      t8++;
    end
    for (int t = t8 + 1; t < MAXC; t++) begin
      v_in[t] = 1'b1;
      s_in[t] = pick();
    end
    s_in[t8+4] = 16'h8000;
    s_in[t8+8] = 16'h7FFF;
    s_in[t8+12] = 16'h0000;
    model(t8 + 700);
    run_seg(t8 + 700);
    chk("to_before", 32'(o_we[t8]), 32'h0);
    chk("to_addr", 32'(o_addr[t8+1]), 32'd52);
    chk("to_din", o_din[t8+1], 32'h1000_0000);
    chk("fmt_8000", o_din[t8+5], 32'h0000_0000);
    chk("fmt_7fff", o_din[t8+9], 32'h1F80_0000);
    chk("fmt_0000", o_din[t8+13], 32'h1000_0000);
    reset_hold(3);

    // random traffic, reset asserted as column 80 appears
    for (int t = 0; t < MAXC; t++) begin
      v_in[t] = ($urandom % 4) != 0;
      s_in[t] = pick();
      n_in[t] = 24'($urandom);
    end
    model(MAXC);
    stop = -1;
    for (int i = MAXC - 1; i >= 0; i--) if (e_we[i] && e_addr[i] == 8'd132) stop = i;
    chk("col80_found", 32'(stop >= 0), 32'h1);
    if (stop >= 0) begin
      run_seg(stop + 1);
      rst_n = 1'b0;
      #1;
      zeros("midrst");
    end
    reset_hold(3);

    for (int t = 0; t < MAXC; t++) begin
      v_in[t] = 1'($urandom % 2);
      s_in[t] = pick();
      n_in[t] = 24'($urandom);
    end
    model(1500);
    run_seg(1500);
    chk("restart_we", 32'(o_we[1]), 32'h1);
    chk("restart_addr", 32'(o_addr[1]), 32'd4);
    reset_hold(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
